// File: rtl/mips_cpu_instr_memory.sv
// ============================================================================
// Module  : mips_cpu_instr_memory
// Brief   : Loadable instruction memory for the Harvard MIPS fetch port with
//           zero-latency fetch, fetch counting, halt and fault reporting.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module mips_cpu_instr_memory #(
   parameter int          DEPTH     = 64,
   parameter logic [31:0] BASE_ADDR = 32'hBFC00000,
   parameter int          COUNT_W   = 16
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               clk_enable,
   input  logic               load_valid,
   output logic               load_ready,
   input  logic [31:0]        load_data,
   input  logic               load_last,
   output logic               mem_ready,
   input  logic [31:0]        instr_address,
   output logic [31:0]        instr_readdata,
   output logic [COUNT_W-1:0] fetch_count,
   output logic               halted,
   output logic               fault
);

   localparam int                AW          = $clog2(DEPTH);
   localparam logic [AW-1:0]     c_LAST_PTR  = AW'(DEPTH - 1);
   localparam logic [31:0]       c_WIN_BYTES = 32'(4 * DEPTH);
   localparam logic [COUNT_W-1:0] c_CNT_MAX  = '1;

   typedef enum logic [0:0] {
      S_LOAD = 1'b0,
      S_RUN  = 1'b1
   } state_t;

   state_t              r_state;
   state_t              w_state_nxt;
   logic [AW-1:0]       r_wr_ptr;
   logic [AW:0]         r_loaded;
   logic [31:0]         r_mem [DEPTH];
   logic [COUNT_W-1:0]  r_fetch_count;
   logic                r_halted;
   logic                r_fault;

   logic                w_run;
   logic                w_write;
   logic [31:0]         w_offset;
   logic                w_in_window;
   logic                w_aligned;
   logic                w_is_zero;
   logic [AW-1:0]       w_idx;
   logic                w_hit;
   logic                w_fault_evt;
   logic [31:0]         w_word;

   assign w_run   = (r_state == S_RUN);
   assign w_write = (r_state == S_LOAD) && load_valid && !reset;

   // Below-base addresses wrap to huge offsets, so one unsigned compare bounds both sides.
   assign w_offset    = instr_address - BASE_ADDR;
   assign w_in_window = (w_offset < c_WIN_BYTES);
   assign w_aligned   = (instr_address[1:0] == 2'b00);
   assign w_is_zero   = (instr_address == 32'd0);
   assign w_idx       = w_offset[AW+1:2];
   assign w_hit       = ({1'b0, w_idx} < r_loaded);
   assign w_fault_evt = w_run && !w_is_zero && !(w_in_window && w_aligned);
   assign w_word      = r_mem[w_idx];

   always_comb begin
      w_state_nxt    = r_state;
      load_ready     = 1'b0;
      mem_ready      = 1'b0;
      instr_readdata = 32'd0;
      case (r_state)
         S_LOAD: begin
            load_ready = 1'b1;
            if (w_write && (load_last || (r_wr_ptr == c_LAST_PTR))) begin
               w_state_nxt = S_RUN;
            end
         end
         S_RUN: begin
            mem_ready = 1'b1;
            if (!w_is_zero && w_in_window && w_aligned && w_hit) begin
               instr_readdata = {w_word[7:0], w_word[15:8], w_word[23:16], w_word[31:24]};
            end
         end
         default: w_state_nxt = S_LOAD;
      endcase
   end

   // Storage has no reset; stale words stay hidden behind r_loaded.
   always_ff @(posedge clk) begin
      if (w_write) begin
         r_mem[r_wr_ptr] <= load_data;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state       <= S_LOAD;
         r_wr_ptr      <= '0;
         r_loaded      <= '0;
         r_fetch_count <= '0;
         r_halted      <= 1'b0;
         r_fault       <= 1'b0;
      end else begin
         r_state <= w_state_nxt;
         if (w_write) begin
            r_wr_ptr <= r_wr_ptr + 1'b1;
            r_loaded <= r_loaded + 1'b1;
         end
         if (w_run && clk_enable) begin
            if (!r_halted && (r_fetch_count != c_CNT_MAX)) begin
               r_fetch_count <= r_fetch_count + 1'b1;
            end
            if (w_is_zero) begin
               r_halted <= 1'b1;
            end
            if (w_fault_evt) begin
               r_fault <= 1'b1;
            end
         end
      end
   end

   assign fetch_count = r_fetch_count;
   assign halted      = r_halted;
   assign fault       = r_fault;

endmodule

`default_nettype wire

// File: tb/tb_mips_cpu_instr_memory.sv
// ============================================================================
// Module  : tb_mips_cpu_instr_memory
// Brief   : Self-checking bench: directed vector table, corner sequences and
//           randomized traffic against an array-based reference model.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_mips_cpu_instr_memory;

   localparam int          DEPTH   = 64;
   localparam logic [31:0] BASE    = 32'hBFC00000;
   localparam int          COUNT_W = 16;
   localparam int          CMAX    = (1 << COUNT_W) - 1;

   logic               clk = 1'b0;
   logic               reset, clk_enable, load_valid, load_last;
   logic               load_ready, mem_ready, halted, fault;
   logic [31:0]        load_data, instr_address, instr_readdata;
   logic [COUNT_W-1:0] fetch_count;

   always #5 clk = ~clk;

   mips_cpu_instr_memory #(.DEPTH(DEPTH), .BASE_ADDR(BASE), .COUNT_W(COUNT_W)) dut (
      .clk            (clk),
      .reset          (reset),
      .clk_enable     (clk_enable),
      .load_valid     (load_valid),
      .load_ready     (load_ready),
      .load_data      (load_data),
      .load_last      (load_last),
      .mem_ready      (mem_ready),
      .instr_address  (instr_address),
      .instr_readdata (instr_readdata),
      .fetch_count    (fetch_count),
      .halted         (halted),
      .fault          (fault)
   );

   // Reference model: program image, number of loaded words, phase and status.
   logic [31:0] m_mem [DEPTH];
   int          m_loaded;
   bit          m_run;
   int          m_count;
   bit          m_halt, m_fault;

   int n_vec = 0;
   int n_err = 0;

   typedef struct {
      string       name;
      logic        rst, ce, vld;
      logic [31:0] data;
      logic        last;
      logic [31:0] addr;
      logic        e_rdy, e_mrdy;
      logic [31:0] e_rdata;
      logic [15:0] e_cnt;
      logic        e_h, e_f;
   } vec_t;

   vec_t tv [14];

   function automatic bit in_window(input logic [31:0] a);
      longint off;
      off = longint'(a) - longint'(BASE);
      return (off >= 0) && (off < 4 * DEPTH) && (a % 4 == 0);
   endfunction

   function automatic logic [31:0] exp_rdata(input logic [31:0] a);
      longint      idx;
      logic [31:0] w;
      if (!m_run || a == 32'd0 || !in_window(a)) return 32'd0;
      idx = (longint'(a) - longint'(BASE)) / 4;
      if (idx >= m_loaded) return 32'd0;
      w = m_mem[idx];
      return {<<8{w}};
   endfunction

   task automatic model_edge();
      if (reset) begin
         m_loaded = 0; m_run = 0; m_count = 0; m_halt = 0; m_fault = 0;
      end else if (!m_run) begin
         if (load_valid) begin
            m_mem[m_loaded] = load_data;
            m_loaded++;
            if (load_last || m_loaded == DEPTH) m_run = 1;
         end
      end else if (clk_enable) begin
         if (!m_halt && m_count < CMAX) m_count++;
         if (instr_address == 32'd0) m_halt = 1;
         else if (!in_window(instr_address)) m_fault = 1;
      end
   endtask

   task automatic chk(input string nm, input logic rdy, input logic mrdy, input logic [31:0] rd,
                      input logic [15:0] cnt, input logic h, input logic f);
      n_vec++;
      if (load_ready !== rdy || mem_ready !== mrdy || instr_readdata !== rd ||
          fetch_count !== cnt || halted !== h || fault !== f) begin
         n_err++;
         $display("FAIL %s addr=%h: got rdy=%b mrdy=%b rdata=%h cnt=%0d halt=%b fault=%b, want rdy=%b mrdy=%b rdata=%h cnt=%0d halt=%b fault=%b",
                  nm, instr_address, load_ready, mem_ready, instr_readdata, fetch_count, halted, fault,
                  rdy, mrdy, rd, cnt, h, f);
      end
   endtask

   task automatic drive(input logic r, input logic ce, input logic v, input logic [31:0] d,
                        input logic l, input logic [31:0] a);
      reset = r; clk_enable = ce; load_valid = v; load_data = d; load_last = l; instr_address = a;
   endtask

   // Check outputs for the current inputs against the model, then advance one clock.
   task automatic step(input string nm);
      #1;
      chk(nm, !m_run, m_run, exp_rdata(instr_address), 16'(m_count), m_halt, m_fault);
      model_edge();
      @(posedge clk);
      #1;
   endtask

   initial begin
      drive(1, 0, 0, 0, 0, 0);
      model_edge();
      @(posedge clk);
      #1;

      // Directed table: load two words, serve them, count to halt, then a misaligned fault.
      //             name          rst ce vld data          last addr          rdy mrdy rdata         cnt h  f
      tv[0]  = '{"reset_state",  0, 0, 0, 32'h0,        0, BASE,          1, 0, 32'h0,        0, 0, 0};
      tv[1]  = '{"load_w0",      0, 0, 1, 32'h24010020, 0, BASE,          1, 0, 32'h0,        0, 0, 0};
      tv[2]  = '{"load_w1_last", 0, 0, 1, 32'h10200003, 1, BASE,          1, 0, 32'h0,        0, 0, 0};
      tv[3]  = '{"run_w0",       0, 0, 1, 32'hFFFFFFFF, 0, BASE,          0, 1, 32'h20000124, 0, 0, 0};
      tv[4]  = '{"run_w1",       0, 0, 0, 32'h0,        0, BASE + 4,      0, 1, 32'h03002010, 0, 0, 0};
      tv[5]  = '{"cnt0",         0, 1, 0, 32'h0,        0, BASE,          0, 1, 32'h20000124, 0, 0, 0};
      tv[6]  = '{"cnt1",         0, 1, 0, 32'h0,        0, BASE + 4,      0, 1, 32'h03002010, 1, 0, 0};
      tv[7]  = '{"unloaded_idx", 0, 1, 0, 32'h0,        0, BASE + 8,      0, 1, 32'h0,        2, 0, 0};
      tv[8]  = '{"cnt3",         0, 1, 0, 32'h0,        0, BASE,          0, 1, 32'h20000124, 3, 0, 0};
      tv[9]  = '{"fetch_zero",   0, 1, 0, 32'h0,        0, 32'h0,         0, 1, 32'h0,        4, 0, 0};
      tv[10] = '{"halted_hold",  0, 1, 0, 32'h0,        0, BASE,          0, 1, 32'h20000124, 5, 1, 0};
      tv[11] = '{"zero_nofault", 0, 1, 0, 32'h0,        0, 32'h0,         0, 1, 32'h0,        5, 1, 0};
      tv[12] = '{"misaligned",   0, 1, 0, 32'h0,        0, BASE + 3,      0, 1, 32'h0,        5, 1, 0};
      tv[13] = '{"fault_sticky", 0, 0, 0, 32'h0,        0, BASE + 4,      0, 1, 32'h03002010, 5, 1, 1};
      for (int i = 0; i < 14; i++) begin
         drive(tv[i].rst, tv[i].ce, tv[i].vld, tv[i].data, tv[i].last, tv[i].addr);
         #1;
         chk(tv[i].name, tv[i].e_rdy, tv[i].e_mrdy, tv[i].e_rdata, tv[i].e_cnt, tv[i].e_h, tv[i].e_f);
         model_edge();
         @(posedge clk);
         #1;
      end

      // Two words loaded: unloaded in-window index is silent, misaligned fetch faults.
      drive(1, 0, 0, 0, 0, BASE); step("t2_reset");
      drive(0, 0, 1, 32'hA1B2C3D4, 0, BASE); step("t2_w0");
      drive(0, 0, 1, 32'h01020304, 1, BASE); step("t2_w1");
      drive(0, 1, 0, 0, 0, BASE + 8); step("t2_idx2");
      drive(0, 1, 0, 0, 0, BASE + 3); step("t2_misalign");
      drive(0, 1, 0, 0, 0, BASE); step("t2_fault_set");
      drive(0, 1, 0, 0, 0, BASE - 4); step("t2_below_base");
      drive(0, 0, 0, 0, 0, BASE + 4 * DEPTH); step("t2_above_win");

      // Fill every word without load_last; extra pulses are refused.
      drive(1, 0, 0, 0, 0, BASE); step("t3_reset");
      for (int i = 0; i < DEPTH; i++) begin
         drive(0, 0, 1, $urandom, 0, BASE); step("t3_fill");
      end
      drive(0, 0, 1, 32'hDEADBEEF, 1, BASE); step("t3_extra");
      for (int i = 0; i < DEPTH; i++) begin
         drive(0, 1, 0, 0, 0, BASE + 32'(4 * i)); step("t3_sweep");
      end

      // Reset mid-load (dominates a concurrent load), reload one word, stale words stay masked.
      drive(1, 0, 0, 0, 0, BASE); step("t5_reset");
      for (int i = 0; i < 3; i++) begin
         drive(0, 0, 1, 32'h11111111 * (i + 1), 0, BASE); step("t5_load");
      end
      drive(1, 1, 1, 32'h77777777, 1, BASE); step("t5_reset_mid");
      drive(0, 0, 0, 0, 0, BASE); step("t5_after_reset");
      drive(0, 0, 1, 32'hCAFEF00D, 1, BASE); step("t5_reload");
      for (int i = 0; i < 4; i++) begin
         drive(0, 0, 0, 0, 0, BASE + 32'(4 * i)); step("t5_masked");
      end

      // clk_enable low in RUN: data served, counters frozen.
      for (int i = 0; i < 3; i++) begin
         drive(0, 0, 0, 0, 0, BASE); step("t6_ce_low");
      end
      drive(0, 0, 0, 0, 0, 32'h0); step("t6_zero_ce_low");
      drive(0, 0, 0, 0, 0, 32'h1); step("t6_bad_ce_low");
      drive(0, 1, 0, 0, 0, BASE); step("t6_ce_high");

      // Randomized traffic against the model.
      for (int i = 0; i < 600; i++) begin
         logic [31:0] a;
         int sel;
         sel = $urandom_range(9);
         case (sel)
            0:       a = 32'h0;
            1:       a = BASE + 32'($urandom_range(4 * DEPTH - 1));
            2:       a = $urandom;
            3:       a = BASE - 32'(4 * $urandom_range(1, 4));
            default: a = BASE + 32'(4 * $urandom_range(DEPTH - 1));
         endcase
         drive(($urandom_range(40) == 0), ($urandom_range(3) != 0), $urandom_range(1),
               $urandom, ($urandom_range(7) == 0), a);
         step("rand");
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

`default_nettype wire
